// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared sizing helpers and serializer FSM encoding
package neuron_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

    function automatic int calc_w(input int n_stage);
        return 1 << (n_stage + 1);
    endfunction

    function automatic int calc_cw(input int n_stage);
        return n_stage + 2;
    endfunction

    function automatic int calc_beats(input int n_stage, input int lane_w);
        return calc_w(n_stage) / lane_w;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic bit lane_w_ok(input int n_stage, input int lane_w);
        return is_pow2(lane_w) && (lane_w <= calc_w(n_stage));
    endfunction

endpackage

// File: rtl/thermometer_lane.sv
// rtl/thermometer_lane.sv - maps a signed remaining count to a LANE_W-bit thermometer code
module thermometer_lane #(
    parameter int LANE_W = 8,
    parameter int REM_W  = 8
) (
    input  logic [REM_W-1:0]  rem,
    output logic [LANE_W-1:0] therm
);

    // rem is two's complement: negative means this beat lies wholly past the count
    always_comb begin
        therm = '0;
        if (rem[REM_W-1]) begin
            therm = '0;
        end else if (rem >= REM_W'(LANE_W)) begin
            therm = '1;
        end else begin
            for (int b = 0; b < LANE_W; b++) begin
                therm[b] = (rem > REM_W'(b));
            end
        end
    end

endmodule

// File: rtl/spike_count_serializer.sv
// rtl/spike_count_serializer.sv - expands a spike count into a streamed thermometer vector
module spike_count_serializer
    import neuron_pkg::*;
#(
    parameter int N_STAGE = 5,
    parameter int LANE_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_STAGE+1:0]  cnt_i,
    input  logic                cnt_valid,
    output logic                cnt_ready,
    output logic [LANE_W-1:0]   spk_o,
    output logic                spk_valid,
    input  logic                spk_ready,
    output logic                spk_last,
    output logic                busy
);

    localparam int W       = calc_w(N_STAGE);
    localparam int CW      = calc_cw(N_STAGE);
    localparam int BEATS   = calc_beats(N_STAGE, LANE_W);
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_SH = $clog2(LANE_W);

    if (!lane_w_ok(N_STAGE, LANE_W)) begin : g_bad_lane_w
        $error("LANE_W must be a power of two no larger than 2**(N_STAGE+1)");
    end

    ser_state_t        state, state_nx;
    logic [CW-1:0]     cnt_q;
    logic [BEAT_W-1:0] beat_q;

    logic              last_hs, advance, accept;
    logic [CW-1:0]     cnt_clamped, next_cnt;
    logic [BEAT_W-1:0] next_beat;
    logic [CW:0]       rem;
    logic [LANE_W-1:0] next_spk;

    assign cnt_clamped = (cnt_i > CW'(W)) ? CW'(W) : cnt_i;
    assign last_hs     = spk_valid && spk_ready && spk_last;
    assign advance     = spk_valid && spk_ready && !spk_last;
    assign cnt_ready   = (state == IDLE) || last_hs;
    assign accept      = cnt_valid && cnt_ready;
    assign busy        = (state != IDLE);

    // The thermometer is computed for the beat that will be presented after this edge
    assign next_cnt  = accept ? cnt_clamped : cnt_q;
    assign next_beat = accept ? '0 : beat_q + BEAT_W'(1);
    assign rem       = {1'b0, next_cnt} - ((CW + 1)'(next_beat) << LANE_SH);

    thermometer_lane #(
        .LANE_W (LANE_W),
        .REM_W  (CW + 1)
    ) u_thermometer_lane (
        .rem   (rem),
        .therm (next_spk)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EMIT;
            EMIT:    if (last_hs && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            beat_q    <= '0;
            spk_o     <= '0;
            spk_valid <= 1'b0;
            spk_last  <= 1'b0;
        end else if (accept) begin
            cnt_q     <= cnt_clamped;
            beat_q    <= '0;
            spk_o     <= next_spk;
            spk_valid <= 1'b1;
            spk_last  <= (next_beat == BEAT_W'(BEATS - 1));
        end else if (advance) begin
            beat_q    <= next_beat;
            spk_o     <= next_spk;
            spk_last  <= (next_beat == BEAT_W'(BEATS - 1));
        end else if (last_hs) begin
            beat_q    <= '0;
            spk_o     <= '0;
            spk_valid <= 1'b0;
            spk_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_count_serializer.sv
// tb/tb_spike_count_serializer.sv - directed and loopback bench for spike_count_serializer
module tb_spike_count_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] cnt_i;
    logic       cnt_valid, cnt_ready;
    logic [7:0] spk_o;
    logic       spk_valid, spk_ready, spk_last, busy;

    logic [2:0] b_cnt_i;
    logic       b_cnt_valid, b_cnt_ready;
    logic [3:0] b_spk_o;
    logic       b_spk_valid, b_spk_ready, b_spk_last, b_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spike_count_serializer #(.N_STAGE(5), .LANE_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cnt_i(cnt_i), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .spk_o(spk_o), .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_last(spk_last), .busy(busy)
    );

    spike_count_serializer #(.N_STAGE(1), .LANE_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cnt_i(b_cnt_i), .cnt_valid(b_cnt_valid), .cnt_ready(b_cnt_ready),
        .spk_o(b_spk_o), .spk_valid(b_spk_valid), .spk_ready(b_spk_ready), .spk_last(b_spk_last), .busy(b_busy)
    );

    function automatic logic [7:0] exp_beat(input int c, input int k);
        logic [7:0] r;
        int cc;
        cc = (c > 64) ? 64 : c;
        for (int b = 0; b < 8; b++) r[b] = ((k * 8 + b) < cc);
        return r;
    endfunction

    function automatic logic [3:0] exp_beat_b(input int c);
        logic [3:0] r;
        int cc;
        cc = (c > 4) ? 4 : c;
        for (int b = 0; b < 4; b++) r[b] = (b < cc);
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cnt_i = '0; cnt_valid = 1'b0; spk_ready = 1'b0;
        b_cnt_i = '0; b_cnt_valid = 1'b0; b_spk_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({spk_valid, spk_last, busy, spk_o} !== 11'h0 || cnt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a: got v=%b l=%b busy=%b o=%h rdy=%b want 0 0 0 00 1",
                     spk_valid, spk_last, busy, spk_o, cnt_ready);
        end
        checks++;
        if ({b_spk_valid, b_spk_last, b_busy, b_spk_o} !== 7'h0 || b_cnt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b: got v=%b l=%b busy=%b o=%h rdy=%b want 0 0 0 0 1",
                     b_spk_valid, b_spk_last, b_busy, b_spk_o, b_cnt_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        spk_ready = 1'b1;
        cnt_i = 7'd19; cnt_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle_ready: got %b want 1", cnt_ready);
        end
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({spk_valid, spk_last, spk_o} !== {1'b1, (k == 7), exp_beat(19, k)}) begin
                errors++;
                $display("FAIL basic beat %0d: got v=%b l=%b o=%h want v=1 l=%b o=%h",
                         k, spk_valid, spk_last, spk_o, (k == 7), exp_beat(19, k));
            end
        end
        @(negedge clk);
        checks++;
        if (spk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got v=%b busy=%b want 0 0", spk_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        spk_ready = 1'b1;
        cnt_i = 7'd0; cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_i = 7'd64;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if ({spk_valid, spk_last, spk_o, cnt_ready} !==
                {1'b1, (k % 8 == 7), exp_beat((k < 8) ? 0 : 64, k % 8), (k % 8 == 7)}) begin
                errors++;
                $display("FAIL b2b beat %0d: got v=%b l=%b o=%h rdy=%b want v=1 l=%b o=%h rdy=%b",
                         k, spk_valid, spk_last, spk_o, cnt_ready,
                         (k % 8 == 7), exp_beat((k < 8) ? 0 : 64, k % 8), (k % 8 == 7));
            end
            if (k == 7) begin
                @(posedge clk); #1;
                cnt_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (spk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got v=%b busy=%b want 0 0", spk_valid, busy);
        end
    endtask

    task automatic test_saturation();
        int vals[3] = '{100, 65, 127};
        int pop;
        spk_ready = 1'b1;
        foreach (vals[i]) begin
            pop = 0;
            cnt_i = 7'(vals[i]); cnt_valid = 1'b1;
            @(posedge clk); #1;
            cnt_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (spk_valid) pop += $countones(spk_o);
                checks++;
                if ({spk_valid, spk_last, spk_o} !== {1'b1, (k == 7), 8'hFF}) begin
                    errors++;
                    $display("FAIL sat %0d beat %0d: got v=%b l=%b o=%h want v=1 l=%b o=ff",
                             vals[i], k, spk_valid, spk_last, spk_o, (k == 7));
                end
            end
            checks++;
            if (pop != 64) begin
                errors++;
                $display("FAIL sat %0d popcount: got %0d want 64", vals[i], pop);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        int pop = 0;
        logic held = 1'b0;
        logic [7:0] prev_o = '0;
        logic prev_l = 1'b0;
        spk_ready = 1'b1;
        cnt_i = 7'd13; cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        for (int i = 0; i < 40 && got < 8; i++) begin
            spk_ready = (i % 3 == 0);
            @(negedge clk);
            if (!spk_valid) begin
                checks++; errors++;
                $display("FAIL bp valid dropped at cycle %0d: got v=0 want v=1", i);
            end else begin
                if (held) begin
                    checks++;
                    if (spk_o !== prev_o || spk_last !== prev_l) begin
                        errors++;
                        $display("FAIL bp stall hold cycle %0d: got o=%h l=%b want o=%h l=%b",
                                 i, spk_o, spk_last, prev_o, prev_l);
                    end
                end
                if (spk_ready) begin
                    checks++;
                    if (spk_o !== exp_beat(13, got) || spk_last !== (got == 7)) begin
                        errors++;
                        $display("FAIL bp beat %0d: got o=%h l=%b want o=%h l=%b",
                                 got, spk_o, spk_last, exp_beat(13, got), (got == 7));
                    end
                    pop += $countones(spk_o);
                    got++;
                end
            end
            held = spk_valid && !spk_ready;
            prev_o = spk_o;
            prev_l = spk_last;
            @(posedge clk); #1;
        end
        spk_ready = 1'b1;
        checks++;
        if (got != 8 || pop != 13) begin
            errors++;
            $display("FAIL bp frame: got beats=%0d pop=%0d want beats=8 pop=13", got, pop);
        end
    endtask

    task automatic test_reset_mid_frame();
        spk_ready = 1'b1;
        cnt_i = 7'd40; cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({spk_valid, spk_o} !== {1'b1, exp_beat(40, 3)}) begin
            errors++;
            $display("FAIL rst_mid beat3: got v=%b o=%h want v=1 o=%h", spk_valid, spk_o, exp_beat(40, 3));
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({spk_valid, spk_last, busy, spk_o} !== 11'h0) begin
            errors++;
            $display("FAIL rst_mid async clear: got v=%b l=%b busy=%b o=%h want 0 0 0 00",
                     spk_valid, spk_last, busy, spk_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (spk_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid resumed: got v=%b busy=%b want 0 0", spk_valid, busy);
            end
        end
        @(posedge clk); #1;
        cnt_i = 7'd5; cnt_valid = 1'b1;
        @(posedge clk); #1;
        cnt_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({spk_valid, spk_last, spk_o} !== {1'b1, (k == 7), exp_beat(5, k)}) begin
                errors++;
                $display("FAIL rst_mid new beat %0d: got v=%b l=%b o=%h want v=1 l=%b o=%h",
                         k, spk_valid, spk_last, spk_o, (k == 7), exp_beat(5, k));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        int c, pop, nb, want;
        logic done, acc, bad_last;
        for (int f = 0; f < 1000; f++) begin
            c = $urandom_range(0, 127);
            want = (c > 64) ? 64 : c;
            cnt_i = 7'(c); cnt_valid = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                acc = cnt_ready;
                @(posedge clk); #1;
            end
            cnt_valid = 1'b0;
            pop = 0; nb = 0; done = 1'b0; bad_last = 1'b0;
            for (int t = 0; t < 100 && !done; t++) begin
                spk_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (spk_valid && spk_ready) begin
                    pop += $countones(spk_o);
                    nb++;
                    if (spk_last !== (nb == 8)) bad_last = 1'b1;
                    if (spk_last) done = 1'b1;
                end
                @(posedge clk); #1;
            end
            checks++;
            if (!acc || !done || pop != want || nb != 8 || bad_last) begin
                errors++;
                $display("FAIL loopback frame %0d cnt=%0d: got acc=%b pop=%0d beats=%0d badlast=%b want pop=%0d beats=8",
                         f, c, acc, pop, nb, bad_last, want);
            end
        end
        spk_ready = 1'b1;
    endtask

    task automatic test_single_beat();
        b_spk_ready = 1'b1;
        b_cnt_i = 3'd0; b_cnt_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            if (c < 7) b_cnt_i = 3'(c + 1);
            else b_cnt_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({b_spk_valid, b_spk_last, b_busy, b_cnt_ready, b_spk_o} !== {4'b1111, exp_beat_b(c)}) begin
                errors++;
                $display("FAIL single cnt=%0d: got v=%b l=%b busy=%b rdy=%b o=%h want 1 1 1 1 o=%h",
                         c, b_spk_valid, b_spk_last, b_busy, b_cnt_ready, b_spk_o, exp_beat_b(c));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (b_spk_valid !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got v=%b busy=%b want 0 0", b_spk_valid, b_busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        test_single_beat();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
